// File: rtl/gpa_fhdo_pkg.sv
// Shared definitions for the GPA-FHDO scheduler: FSM encoding, gradient word
// field positions, DAC register codes and the slot-word formatter.
package gpa_fhdo_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  localparam int PAYLOAD_MSB = 23;
  localparam int PAYLOAD_LSB = 0;
  localparam int BCAST_BIT   = 24;
  localparam int CH_MSB      = 26;
  localparam int CH_LSB      = 25;

  localparam logic [3:0] REG_SYNC     = 4'b0010;
  localparam logic [3:0] REG_DAC_BASE = 4'b1000;

  // Serialiser word for a DAC slot: channel in [26:25], payload in [23:0].
  function automatic logic [31:0] slot_word(input logic [1:0] ch, input logic [23:0] payload);
    return {5'b0, ch, 1'b0, payload};
  endfunction

endpackage

// File: rtl/gpa_fhdo_rr_arb.sv
// 4-way round-robin arbiter; the search starts one past the last accepted
// grant and the pointer only moves when the grant is actually taken.
module gpa_fhdo_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       accept,
  output logic [3:0] grant,
  output logic [1:0] idx
);

  logic [1:0] ptr;
  logic [1:0] cand;
  logic       found;

  always_comb begin
    grant = '0;
    idx   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) grant[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (accept)
      ptr <= idx + 2'd1;
  end

endmodule

// File: rtl/gpa_fhdo_sched.sv
// Buffers one word per DAC channel plus one config word and issues them one at a
// time to the SPI serialiser. Optional broadcast writes: GPA_FHDO_SCHED_BCAST_EN.
module gpa_fhdo_sched
  import gpa_fhdo_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 128,
  parameter int NUM_CH       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       grad_data_i,
  input  logic              grad_valid_i,
  input  logic [31:0]       cfg_data_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  output logic [31:0]       ser_data_o,
  output logic              ser_valid_o,
  input  logic              ser_busy_i,
  output logic [NUM_CH-1:0] pending_o,
  output logic              overrun_o,
  output logic              timeout_o,
  input  logic              clr_i,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  state_t             state, state_next;
  logic [23:0]        payload [NUM_CH];
  logic [NUM_CH-1:0]  slot_valid;
  logic [NUM_CH-1:0]  wr_vec, clr_vec;
  logic [31:0]        cfg_word;
  logic               cfg_full, cfg_accept;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         grant;
  logic [1:0]         grant_idx, wr_ch;
  logic               latch_cfg, latch_slot, timeout_hit, overrun_hit, bcast_sel;
  logic               unused_bits;

  assign unused_bits = ^{grad_data_i[31:27], grad_data_i[BCAST_BIT]};

  gpa_fhdo_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (slot_valid),
    .accept (latch_slot),
    .grant  (grant),
    .idx    (grant_idx)
  );

  always_comb begin
    state_next  = state;
    latch_cfg   = 1'b0;
    latch_slot  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_full) begin
          latch_cfg  = 1'b1;
          state_next = S_ISSUE;
        end else if (|slot_valid) begin
          latch_slot = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (ser_busy_i)
          state_next = S_WAIT_DONE;
        else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end
      end
      S_WAIT_DONE: if (!ser_busy_i) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Counts from the ISSUE cycle so the limit is measured from the valid strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (state == S_IDLE)
      cnt <= '0;
    else if (state == S_ISSUE || state == S_WAIT_BUSY)
      cnt <= cnt + 1'b1;
  end

  always_comb begin
`ifdef GPA_FHDO_SCHED_BCAST_EN
    bcast_sel = grad_data_i[BCAST_BIT];
`else
    bcast_sel = 1'b0;
`endif
    wr_ch  = grad_data_i[CH_MSB:CH_LSB];
    wr_vec = '0;
    if (grad_valid_i) begin
      if (bcast_sel) wr_vec = '1;
      else           wr_vec[wr_ch] = 1'b1;
    end
    clr_vec     = latch_slot ? grant : '0;
    overrun_hit = |(wr_vec & slot_valid & ~clr_vec);
    cfg_accept  = cfg_valid_i && !cfg_full;
  end

  // A write landing on the slot being latched keeps it valid for the next round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
      for (int i = 0; i < NUM_CH; i++) payload[i] <= '0;
    end else begin
      slot_valid <= (slot_valid & ~clr_vec) | wr_vec;
      for (int i = 0; i < NUM_CH; i++)
        if (wr_vec[i]) payload[i] <= grad_data_i[PAYLOAD_MSB:PAYLOAD_LSB];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_full <= 1'b0;
      cfg_word <= '0;
    end else if (cfg_accept) begin
      cfg_full <= 1'b1;
      cfg_word <= cfg_data_i;
    end else if (latch_cfg) begin
      cfg_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ser_data_o <= '0;
    else if (latch_cfg)
      ser_data_o <= cfg_word;
    else if (latch_slot)
      ser_data_o <= slot_word(grant_idx, payload[grant_idx]);
  end

  // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      if (overrun_hit)  overrun_o <= 1'b1;
      else if (clr_i)   overrun_o <= 1'b0;
      if (timeout_hit)  timeout_o <= 1'b1;
      else if (clr_i)   timeout_o <= 1'b0;
    end
  end

  assign cfg_ready_o = !cfg_full;
  assign ser_valid_o = (state == S_ISSUE);
  assign busy_o      = (state != S_IDLE);
  assign pending_o   = slot_valid;

endmodule

// File: tb/tb_gpa_fhdo_sched.sv
// Directed self-checking bench for gpa_fhdo_sched with a simple serialiser model
// that raises busy a few cycles after each valid strobe and drops it later.
module tb_gpa_fhdo_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] grad_data_i;
  logic        grad_valid_i;
  logic [31:0] cfg_data_i;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [31:0] ser_data_o;
  logic        ser_valid_o;
  logic        ser_busy_i = 1'b0;
  logic [3:0]  pending_o;
  logic        overrun_o;
  logic        timeout_o;
  logic        clr_i;
  logic        busy_o;

  int          tests = 0;
  int          failures = 0;
  int          ser_cnt = 0;
  bit          ser_en = 1'b1;
  logic [31:0] issued_q[$];

  gpa_fhdo_sched dut (
    .clk          (clk),
    .rst          (rst),
    .grad_data_i  (grad_data_i),
    .grad_valid_i (grad_valid_i),
    .cfg_data_i   (cfg_data_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .ser_data_o   (ser_data_o),
    .ser_valid_o  (ser_valid_o),
    .ser_busy_i   (ser_busy_i),
    .pending_o    (pending_o),
    .overrun_o    (overrun_o),
    .timeout_o    (timeout_o),
    .clr_i        (clr_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Serialiser model: logs every issued word; busy rises 3 cycles after valid, falls 10 later.
  always @(posedge clk) begin
    if (ser_valid_o) begin
      issued_q.push_back(ser_data_o);
      if (ser_en) ser_cnt <= 1;
    end else if (ser_cnt != 0) begin
      ser_cnt <= ser_cnt + 1;
      if (ser_cnt == 3) ser_busy_i <= 1'b1;
      if (ser_cnt == 13) begin
        ser_busy_i <= 1'b0;
        ser_cnt    <= 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] gd, input logic gv,
                               input logic [31:0] cd, input logic cv);
    grad_data_i  = gd;
    grad_valid_i = gv;
    cfg_data_i   = cd;
    cfg_valid_i  = cv;
    @(negedge clk);
    grad_valid_i = 1'b0;
    cfg_valid_i  = 1'b0;
  endtask

  task automatic pulseClear();
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issued_q.delete();
  endtask

  task automatic waitIdle(input string tag);
    int k = 0;
    while (!(busy_o == 1'b0 && pending_o == 4'b0 && cfg_ready_o == 1'b1) && k < 500) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, 32'(k < 500), 32'd1);
  endtask

  task automatic waitLog(input int n, input string tag);
    int k = 0;
    while (issued_q.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, 32'(k < 500), 32'd1);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    grad_data_i = '0; grad_valid_i = 1'b0;
    cfg_data_i = '0;  cfg_valid_i = 1'b0;
    clr_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_ser_valid", 32'(ser_valid_o), 0);
    checkOutput("rst_ser_data",  ser_data_o, 0);
    checkOutput("rst_cfg_ready", 32'(cfg_ready_o), 1);
    checkOutput("rst_pending",   32'(pending_o), 0);
    checkOutput("rst_overrun",   32'(overrun_o), 0);
    checkOutput("rst_timeout",   32'(timeout_o), 0);
    checkOutput("rst_busy",      32'(busy_o), 0);

    // Single word: bits [26:25] of 0x0200_1234 select channel 1.
    applyStimulus(32'h0200_1234, 1'b1, 32'h0, 1'b0);
    checkOutput("single_pending", 32'(pending_o), 32'b0010);
    @(negedge clk);
    checkOutput("single_valid", 32'(ser_valid_o), 1);
    checkOutput("single_data",  ser_data_o, 32'h0200_1234);
    waitIdle("single_idle");
    checkOutput("single_count", issued_q.size(), 1);
    checkOutput("single_log",   issued_q[0], 32'h0200_1234);
    checkOutput("single_busy",  32'(busy_o), 0);
    checkOutput("single_hold",  ser_data_o, 32'h0200_1234);

    // Round-robin order ch0, ch1, ch3 from a freshly reset pointer.
    doReset();
    applyStimulus(32'h0000_0011, 1'b1, 32'h0, 1'b0);
    checkOutput("rr_pend_a", 32'(pending_o), 32'b0001);
    applyStimulus(32'h0200_0022, 1'b1, 32'h0, 1'b0);
    checkOutput("rr_pend_b", 32'(pending_o), 32'b0010);
    applyStimulus(32'h0600_0033, 1'b1, 32'h0, 1'b0);
    checkOutput("rr_pend_c", 32'(pending_o), 32'b1010);
    waitLog(2, "rr_wait2");
    checkOutput("rr_pend_d", 32'(pending_o), 32'b1000);
    waitIdle("rr_idle");
    checkOutput("rr_pend_e", 32'(pending_o), 32'b0000);
    checkOutput("rr_count", issued_q.size(), 3);
    checkOutput("rr_first",  issued_q[0], 32'h0000_0011);
    checkOutput("rr_second", issued_q[1], 32'h0200_0022);
    checkOutput("rr_third",  issued_q[2], 32'h0600_0033);

    // Overrun: two ch1 writes while ch0 is in flight, only the second survives.
    doReset();
    applyStimulus(32'h0000_0001, 1'b1, 32'h0, 1'b0);
    applyStimulus(32'h0200_AAAA, 1'b1, 32'h0, 1'b0);
    checkOutput("ovr_before", 32'(overrun_o), 0);
    applyStimulus(32'h0200_BBBB, 1'b1, 32'h0, 1'b0);
    checkOutput("ovr_set",  32'(overrun_o), 1);
    checkOutput("ovr_pend", 32'(pending_o), 32'b0010);
    waitIdle("ovr_idle");
    checkOutput("ovr_count", issued_q.size(), 2);
    checkOutput("ovr_first", issued_q[0], 32'h0000_0001);
    checkOutput("ovr_word",  issued_q[1], 32'h0200_BBBB);
    checkOutput("ovr_sticky", 32'(overrun_o), 1);
    pulseClear();
    checkOutput("ovr_clear", 32'(overrun_o), 0);

    // Config and ch0 in the same cycle: config goes first.
    doReset();
    applyStimulus(32'h0000_0077, 1'b1, 32'h0002_0000, 1'b1);
    checkOutput("cfg_ready_low", 32'(cfg_ready_o), 0);
    checkOutput("cfg_pend",      32'(pending_o), 32'b0001);
    @(negedge clk);
    checkOutput("cfg_ready_high", 32'(cfg_ready_o), 1);
    checkOutput("cfg_issue_data", ser_data_o, 32'h0002_0000);
    waitIdle("cfg_idle");
    checkOutput("cfg_count", issued_q.size(), 2);
    checkOutput("cfg_first", issued_q[0], 32'h0002_0000);
    checkOutput("cfg_then",  issued_q[1], 32'h0000_0077);

    // Busy never rises: timeout flag appears in cycle 128 after the valid strobe.
    ser_en = 1'b0;
    applyStimulus(32'h0400_0099, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("to_valid", 32'(ser_valid_o), 1);
    k = 0;
    while (!timeout_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    checkOutput("to_cycle", k, 128);
    checkOutput("to_busy",  32'(busy_o), 0);
    pulseClear();
    checkOutput("to_clear", 32'(timeout_o), 0);
    ser_en = 1'b1;

    doReset();
`ifdef GPA_FHDO_SCHED_BCAST_EN
    applyStimulus(32'h0100_0055, 1'b1, 32'h0, 1'b0);
    checkOutput("bc_pend", 32'(pending_o), 32'b1111);
    waitIdle("bc_idle");
    checkOutput("bc_count", issued_q.size(), 4);
    checkOutput("bc_ch0", issued_q[0], 32'h0000_0055);
    checkOutput("bc_ch1", issued_q[1], 32'h0200_0055);
    checkOutput("bc_ch2", issued_q[2], 32'h0400_0055);
    checkOutput("bc_ch3", issued_q[3], 32'h0600_0055);
    doReset();
    applyStimulus(32'h0100_0066, 1'b1, 32'h0, 1'b0);
`else
    applyStimulus(32'h0100_0055, 1'b1, 32'h0, 1'b0);
    checkOutput("nobc_pend", 32'(pending_o), 32'b0001);
    waitIdle("nobc_idle");
    checkOutput("nobc_count", issued_q.size(), 1);
    checkOutput("nobc_word",  issued_q[0], 32'h0000_0055);
    doReset();
    applyStimulus(32'h0000_0005, 1'b1, 32'h0, 1'b0);
    applyStimulus(32'h0200_0006, 1'b1, 32'h0, 1'b0);
`endif

    // Reset during the second transfer clears every output at once.
    waitLog(2, "mid_wait2");
    repeat (3) @(negedge clk);
    checkOutput("mid_busy", 32'(busy_o), 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_ser_valid", 32'(ser_valid_o), 0);
    checkOutput("mid_ser_data",  ser_data_o, 0);
    checkOutput("mid_cfg_ready", 32'(cfg_ready_o), 1);
    checkOutput("mid_pending",   32'(pending_o), 0);
    checkOutput("mid_overrun",   32'(overrun_o), 0);
    checkOutput("mid_timeout",   32'(timeout_o), 0);
    checkOutput("mid_busy_rst",  32'(busy_o), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
